// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the 16-by-8 sequential divider
package div_pkg;

    localparam int DIVIDEND_W_DEF = 16;
    localparam int DIVISOR_W_DEF  = 8;
    localparam int CNT_W          = 4;

    localparam logic [15:0] ZERO_DIV_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_divisor,
    output logic [W:0]   o_rem,
    output logic         o_qbit
);

    logic [W+1:0] w_shift;
    logic         w_ge;

    // One spare bit on top keeps the compare exact even if the incoming remainder is wide.
    assign w_shift = {i_rem, i_bit};
    assign w_ge    = (w_shift >= {2'b00, i_divisor});
    assign o_qbit  = w_ge;
    assign o_rem   = w_ge ? (W+1)'(w_shift - {2'b00, i_divisor}) : w_shift[W:0];

endmodule

// File: rtl/vedic_8X8.sv
// rtl/vedic_8X8.sv - 8x8 unsigned multiplier from 4x4 vertical/crosswise partials (only with DIV_SELF_CHECK_EN)
`ifdef DIV_SELF_CHECK_EN
module vedic_8X8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    logic [7:0]  w_ll;
    logic [7:0]  w_lh;
    logic [7:0]  w_hl;
    logic [7:0]  w_hh;
    logic [15:0] w_mid;

    assign w_ll  = a[3:0] * b[3:0];
    assign w_lh  = a[3:0] * b[7:4];
    assign w_hl  = a[7:4] * b[3:0];
    assign w_hh  = a[7:4] * b[7:4];
    assign w_mid = {8'h00, w_lh} + {8'h00, w_hl};
    assign p     = {8'h00, w_ll} + {w_mid[11:0], 4'h0} + {w_hh, 8'h00};

endmodule
`endif

// File: rtl/seq_divider_16_by_8.sv
// rtl/seq_divider_16_by_8.sv - iterative restoring divider, one quotient bit per clock
// Optional product-based result self-check enabled by defining DIV_SELF_CHECK_EN.
module seq_divider_16_by_8
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  check_err
);

    div_state_t            r_state;
    div_state_t            w_next_state;
    logic [CNT_W-1:0]      r_count;
    logic [DIVISOR_W:0]    r_rem;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVIDEND_W-1:0] r_dq;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_div_by_zero;
    logic                  r_out_valid;
    logic [DIVISOR_W:0]    w_next_rem;
    logic                  w_qbit;
    logic                  w_last;

    div_step #(.W(DIVISOR_W)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dq[DIVIDEND_W-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_next_rem),
        .o_qbit    (w_qbit)
    );

    assign w_last = (r_count == '1);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (in_valid) w_next_state = (divisor == '0) ? DONE : CALC;
            CALC: if (w_last) w_next_state = DONE;
            DONE: if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // r_dq starts as the dividend and fills with quotient bits as dividend bits leave the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_rem         <= '0;
            r_divisor     <= '0;
            r_dq          <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_out_valid   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= (w_next_state == DONE);
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_divisor     <= divisor;
                        r_dq          <= dividend;
                        r_rem         <= '0;
                        r_count       <= '0;
                        r_div_by_zero <= (divisor == '0);
                        if (divisor == '0) begin
                            r_quotient  <= DIVIDEND_W'(ZERO_DIV_QUOT);
                            r_remainder <= dividend[DIVISOR_W-1:0];
                        end
                    end
                end
                CALC: begin
                    r_rem   <= w_next_rem;
                    r_dq    <= {r_dq[DIVIDEND_W-2:0], w_qbit};
                    r_count <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_quotient  <= {r_dq[DIVIDEND_W-2:0], w_qbit};
                        r_remainder <= w_next_rem[DIVISOR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

`ifdef DIV_SELF_CHECK_EN
    logic [DIVIDEND_W-1:0]           r_dividend_chk;
    logic [2*DIVISOR_W-1:0]          w_p_lo;
    logic [2*DIVISOR_W-1:0]          w_p_hi;
    logic [DIVIDEND_W+DIVISOR_W-1:0] w_recon;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dividend_chk <= '0;
        end else if (in_ready && in_valid) begin
            r_dividend_chk <= dividend;
        end
    end

    vedic_8X8 u_mul_lo (.a(r_quotient[7:0]),  .b(r_divisor), .p(w_p_lo));
    vedic_8X8 u_mul_hi (.a(r_quotient[15:8]), .b(r_divisor), .p(w_p_hi));

    assign w_recon   = {8'h00, w_p_lo} + {w_p_hi, 8'h00} + {16'h0000, r_remainder};
    assign check_err = r_out_valid && !r_div_by_zero && (w_recon != {8'h00, r_dividend_chk});
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider_16_by_8.sv
// tb/tb_seq_divider_16_by_8.sv - directed self-checking bench for seq_divider_16_by_8
module tb_seq_divider_16_by_8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        check_err;

    int vectors = 0;
    int miscompares = 0;

    seq_divider_16_by_8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .check_err   (check_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain, 1: hold out_ready low 10 cycles, 2: pulse foreign operands during CALC
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er,
                          input logic edbz, input int elat, input int mode);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("in_ready_before_op", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        dividend = 16'h0;
        divisor  = 8'h0;
        cyc = 0;
        if (elat > 0) chk("in_ready_calc", {31'd0, in_ready}, 32'd0);
        while (!out_valid && cyc < 100) begin
            if (mode == 2 && cyc == 3) begin
                in_valid = 1'b1;
                dividend = 16'hBEEF;
                divisor  = 8'h05;
            end
            tick();
            cyc++;
            if (mode == 2 && cyc == 4) in_valid = 1'b0;
        end
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("edges_after_accept", cyc, elat);
        chk("quotient", {16'd0, quotient}, {16'd0, eq});
        chk("remainder", {24'd0, remainder}, {24'd0, er});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, edbz});
        chk("check_err", {31'd0, check_err}, 32'd0);
        if (mode == 1) begin
            for (int i = 0; i < 10; i++) begin
                tick();
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                chk("bp_quotient", {16'd0, quotient}, {16'd0, eq});
                chk("bp_remainder", {24'd0, remainder}, {24'd0, er});
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 16'h0;
        divisor   = 8'h0;
        repeat (3) tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_remainder", {24'd0, remainder}, 32'd0);
        chk("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
        chk("rst_check_err", {31'd0, check_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op(16'd1000, 8'd7,   16'd142,   8'd6,    1'b0, 16, 0);
        run_op(16'hFFFF, 8'hFF,  16'h0101,  8'h00,   1'b0, 16, 0);
        run_op(16'hFFFF, 8'h01,  16'hFFFF,  8'h00,   1'b0, 16, 0);
        run_op(16'd5,    8'd9,   16'd0,     8'd5,    1'b0, 16, 0);
        run_op(16'h0000, 8'h80,  16'h0000,  8'h00,   1'b0, 16, 0);
        run_op(16'h1234, 8'h00,  16'hFFFF,  8'h34,   1'b1, 0,  0);
        run_op(16'h00FF, 8'h10,  16'h000F,  8'h0F,   1'b0, 16, 0);
        run_op(16'd50001, 8'd200, 16'd250,  8'd1,    1'b0, 16, 1);
        run_op(16'd40000, 8'd3,  16'd13333, 8'd1,    1'b0, 16, 2);

        // Mid-operation reset after eight iterations; prior result is nonzero.
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        chk("mid_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_quotient", {16'd0, quotient}, 32'd0);
        chk("mid_rst_remainder", {24'd0, remainder}, 32'd0);
        chk("mid_rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
        chk("mid_rst_check_err", {31'd0, check_err}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, 0);

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 8'($urandom_range(1, 255));
            run_op(ra, rb, ra / {8'd0, rb}, 8'(ra % {8'd0, rb}), 1'b0, 16, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
